// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0004,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        exc_en,
    output logic        imem_en,
    output logic [30:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] if_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic        id_adel
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2
    } ifid_act_t;

    logic [31:0] pc_f_r;
    logic        f_valid_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc_plus4_s;
    ifid_act_t   ifid_act_s;

    function automatic logic misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Next-PC selection; bit 31 (kernel segment) survives the low-31-bit wrap.
    always_comb begin
        pc_plus4_s = {pc_f_r[31], pc_f_r[30:0] + 31'd4};
        if (exc_en) begin
            pc_next_s = EXC_VECTOR;
        end else if (redirect_en) begin
            pc_next_s = redirect_pc;
        end else if (!f_valid_r) begin
            pc_next_s = pc_f_r;
        end else if (stall) begin
            pc_next_s = pc_f_r;
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // IF/ID action: redirects beat stall so a squashed slot never lingers.
    always_comb begin
        if (exc_en || redirect_en) begin
            ifid_act_s = ACT_BUBBLE;
        end else if (stall) begin
            ifid_act_s = ACT_HOLD;
        end else if (!f_valid_r) begin
            ifid_act_s = ACT_BUBBLE;
        end else begin
            ifid_act_s = ACT_LOAD;
        end
    end

    // Addressing pc_next keeps imem_dout aligned with pc_f despite the 1-cycle read latency.
    assign imem_en   = ~reset;
    assign imem_addr = pc_next_s[30:0];
    assign if_pc     = pc_f_r;

    // PC register and fetch-valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_r    <= RESET_PC;
            f_valid_r <= 1'b0;
        end else begin
            pc_f_r    <= pc_next_s;
            f_valid_r <= 1'b1;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid    <= 1'b0;
            id_pc       <= 32'h0000_0000;
            id_pc_plus4 <= 32'h0000_0000;
            id_instr    <= NOP_INSTR;
            id_adel     <= 1'b0;
        end else begin
            case (ifid_act_s)
                ACT_LOAD: begin
                    id_valid    <= 1'b1;
                    id_pc       <= pc_f_r;
                    id_pc_plus4 <= pc_plus4_s;
                    id_adel     <= misaligned(pc_f_r);
                    id_instr    <= misaligned(pc_f_r) ? NOP_INSTR : imem_dout;
                end
                ACT_BUBBLE: begin
                    id_valid <= 1'b0;
                    id_instr <= NOP_INSTR;
                    id_adel  <= 1'b0;
                end
                ACT_HOLD: begin
                    id_valid <= id_valid;
                end
                default: begin
                    id_valid <= 1'b0;
                    id_instr <= NOP_INSTR;
                    id_adel  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    // Fetch and bubble/stall-hold counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt  <= 32'd0;
            perf_bubble_cnt <= 32'd0;
        end else begin
            case (ifid_act_s)
                ACT_LOAD:   perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
                ACT_BUBBLE: perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
                ACT_HOLD:   perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
                default:    perf_fetch_cnt  <= perf_fetch_cnt;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory returns word = byte address; IF/ID
// expectations are queued as each cycle is driven and popped after the edge.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        exc_en;
    logic        imem_en;
    logic [30:0] imem_addr;
    logic [31:0] imem_dout = 32'h0000_0000;
    logic [31:0] if_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        id_adel;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string       tag;
        logic        full;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] plus4;
        logic [31:0] instr;
        logic        adel;
    } exp_t;
    exp_t sb[$];

    if_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .exc_en      (exc_en),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_dout   (imem_dout),
        .if_pc       (if_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .id_adel     (id_adel)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory whose contents equal the byte address.
    always @(posedge clk) begin
        if (imem_en) imem_dout <= {1'b0, imem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic full, input logic valid,
                            input logic [31:0] pc, input logic [31:0] plus4,
                            input logic [31:0] instr, input logic adel);
        exp_t e;
        e.tag = tag; e.full = full; e.valid = valid; e.pc = pc;
        e.plus4 = plus4; e.instr = instr; e.adel = adel;
        sb.push_back(e);
    endtask

    task automatic push_bubble(input string tag);
        push_exp(tag, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
    endtask

    task automatic push_load(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic adel);
        push_exp(tag, 1'b1, 1'b1, pc, pc + 32'd4, instr, adel);
    endtask

    task automatic check_id();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_valid"}, {31'd0, id_valid}, {31'd0, e.valid});
            chk({e.tag, "_instr"}, id_instr, e.instr);
            chk({e.tag, "_adel"},  {31'd0, id_adel}, {31'd0, e.adel});
            if (e.full) begin
                chk({e.tag, "_pc"},    id_pc, e.pc);
                chk({e.tag, "_plus4"}, id_pc_plus4, e.plus4);
            end
        end
    endtask

    task automatic step();
        tick();
        check_id();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0; exc_en = 1'b0;
        tick();
        tick();
        chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h8000_0000);
        push_exp("rst", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_id();
`ifdef IF_PERF_CNT_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_bubble", perf_bubble_cnt, 32'd0);
`endif

        // Startup: address 0 re-fetched once, first instruction on the 2nd edge.
        reset = 1'b0;
        #1;
        chk("start_imem_en", {31'd0, imem_en}, 32'd1);
        chk("start_addr0", {1'b0, imem_addr}, 32'h0);
        push_bubble("start_b");
        step();
        chk("start_addr1", {1'b0, imem_addr}, 32'h4);
        chk("start_if_pc", if_pc, 32'h8000_0000);
        push_load("start_i0", 32'h8000_0000, 32'h0, 1'b0);
        step();
        push_load("seq_i1", 32'h8000_0004, 32'h4, 1'b0);
        step();
        push_load("seq_i2", 32'h8000_0008, 32'h8, 1'b0);
        step();

        // Stall for three cycles holding 0x80000008.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_addr", {1'b0, imem_addr}, 32'h0C);
            push_load("stall_hold", 32'h8000_0008, 32'h8, 1'b0);
            step();
            chk("stall_if_pc", if_pc, 32'h8000_000C);
        end
        stall = 1'b0;
        push_load("stall_rel", 32'h8000_000C, 32'h0C, 1'b0);
        step();

        // Taken branch.
        redirect_en = 1'b1; redirect_pc = 32'h8000_0040;
        #1;
        chk("redir_addr", {1'b0, imem_addr}, 32'h40);
        push_bubble("redir_b");
        step();
        chk("redir_if_pc", if_pc, 32'h8000_0040);
        redirect_en = 1'b0;
        push_load("redir_tgt", 32'h8000_0040, 32'h40, 1'b0);
        step();

        // Misaligned target keeps fetching sequentially with AdEL flagged.
        redirect_en = 1'b1; redirect_pc = 32'h8000_0042;
        push_bubble("mis_b");
        step();
        redirect_en = 1'b0;
        push_load("mis_0", 32'h8000_0042, 32'h0, 1'b1);
        step();
        push_load("mis_1", 32'h8000_0046, 32'h0, 1'b1);
        step();

        // Exception beats redirect and stall; exception alone beats stall.
        exc_en = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h8000_0100; stall = 1'b1;
        #1;
        chk("prio_addr", {1'b0, imem_addr}, 32'h4);
        push_bubble("prio_all");
        step();
        chk("prio_if_pc", if_pc, 32'h8000_0004);
        redirect_en = 1'b0;
        push_bubble("prio_exc_stall");
        step();
        chk("prio2_if_pc", if_pc, 32'h8000_0004);
        exc_en = 1'b0; stall = 1'b0;
        push_load("exc_vec", 32'h8000_0004, 32'h4, 1'b0);
        step();

        // Low 31 bits wrap while bit 31 is kept.
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        push_bubble("wrap_b");
        step();
        chk("wrap_if_pc0", if_pc, 32'hFFFF_FFFC);
        redirect_en = 1'b0;
        #1;
        chk("wrap_addr", {1'b0, imem_addr}, 32'h0);
        push_exp("wrap_i", 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h8000_0000, 32'h7FFF_FFFC, 1'b0);
        step();
        chk("wrap_if_pc1", if_pc, 32'h8000_0000);

        // Reset mid-run restarts the startup sequence.
        reset = 1'b1;
        #1;
        chk("mrst_imem_en", {31'd0, imem_en}, 32'd0);
        push_exp("mrst", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("mrst_addr0", {1'b0, imem_addr}, 32'h0);
        push_bubble("mrst_b");
        step();
        chk("mrst_addr1", {1'b0, imem_addr}, 32'h4);
        push_load("mrst_i0", 32'h8000_0000, 32'h0, 1'b0);
        step();
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, 32'd1);
        chk("perf_bubble", perf_bubble_cnt, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS32 pipeline.
- Owns the PC register and drives the synchronous-read InstructionMem (`en`/`Address[30:0]` in, `dout[31:0]` out, 1-cycle read latency).
- Selects the next PC from sequential, redirect or exception sources.
- Registers {pc, pc+4, instr, flags} into the IF/ID pipeline register consumed by decode.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h8000_0004, PC loaded when exc_en asserted.
- NOP_INSTR, 32'h0000_0000, instruction word inserted for bubbles and faulted fetches.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect_en  in  1  branch/jump resolved taken (from EX).
- redirect_pc  in  32  target for redirect_en.
- exc_en  in  1  exception/interrupt taken (from MEM/CP0).
- imem_en  out  1  memory enable to InstructionMem.
- imem_addr  out  31  memory address (byte address, bits 30:0).
- imem_dout  in  32  InstructionMem read data.
- if_pc  out  32  PC of word currently arriving on imem_dout (debug/CP0 EPC).
- id_valid  out  1  IF/ID holds a real instruction.
- id_pc  out  32  IF/ID PC.
- id_pc_plus4  out  32  IF/ID PC+4.
- id_instr  out  32  IF/ID instruction.
- id_adel  out  1  IF/ID fetch address misaligned (AdEL on fetch).

Behaviour:
- State: pc_f[31:0], f_valid, IF/ID register {id_valid, id_pc, id_pc_plus4, id_instr, id_adel}.
- Reset values:
  - pc_f = RESET_PC, f_valid = 0.
  - id_valid = 0, id_pc = 0, id_pc_plus4 = 0, id_instr = NOP_INSTR, id_adel = 0.
  - imem_en = 0 while reset = 1.
- imem_en = ~reset.
- imem_addr = pc_next[30:0] (combinational), so the word for pc_f is on imem_dout in the cycle pc_f is current.
- pc_plus4 = {pc_f[31], pc_f[30:0] + 31'd4}.
  - Bit 31 (kernel bit) is preserved.
  - The low 31 bits wrap from 31'h7FFF_FFFC to 0.
- pc_next priority, highest first:
  1. exc_en → EXC_VECTOR.
  2. redirect_en → redirect_pc.
  3. f_valid == 0 → pc_f (startup re-fetch).
  4. stall → pc_f (re-read same word, keeps dout aligned).
  5. otherwise → pc_plus4.
- pc_f <= pc_next every cycle when not in reset.
- f_valid <= 1 the first cycle after reset deasserts.
  - The first instruction reaches IF/ID two edges after reset drops.
- IF/ID update, highest priority first:
  - reset → reset values.
  - exc_en or redirect_en → bubble: id_valid = 0, id_instr = NOP_INSTR, id_adel = 0. Redirect/exception override stall.
  - stall → hold all IF/ID fields.
  - f_valid == 0 → bubble.
  - otherwise → id_valid = 1, id_pc = pc_f, id_pc_plus4 = pc_plus4, id_instr = imem_dout, id_adel = (pc_f[1:0] != 0).
    - When id_adel = 1, id_instr = NOP_INSTR regardless of imem_dout.
- Misaligned PCs are not corrected; fetch continues sequentially until the exception redirects via exc_en.
- if_pc = pc_f.
- Reset mid-stream: all in-flight fetches are discarded and startup restarts from RESET_PC.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds two 32-bit outputs:
  - perf_fetch_cnt: increments each cycle IF/ID loads id_valid = 1.
  - perf_bubble_cnt: increments each cycle IF/ID loads a bubble, or holds under stall.
- Both counters reset to 0, wrap at 2^32, and are unaffected by stall except as described.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset startup: release reset, memory preloaded with word = address → imem_addr 0x0 for two cycles, then 0x4, 0x8…; id_valid rises on the 2nd edge after reset with id_pc = 0x80000000, id_instr = 0x00000000 and id_pc_plus4 = 0x80000004; next cycles id_pc = 0x80000004, 0x80000008.
- Stall: assert stall 3 cycles at id_pc = 0x80000008 → IF/ID holds 0x80000008 for 3 cycles; imem_addr stays 0x0C; release → id_pc = 0x8000000C with the correct word, no skip or duplicate.
- Branch redirect: redirect_en with redirect_pc = 0x80000040 for one cycle → next IF/ID is a bubble (id_valid = 0, id_instr = 0); following cycle id_pc = 0x80000040.
- Priority: exc_en, redirect_en and stall together → pc_f = 0x80000004 (EXC_VECTOR); IF/ID bubble; exc_en alone overrides stall likewise.
- Misaligned target: redirect_pc = 0x80000042 → IF/ID shows id_valid = 1, id_adel = 1, id_instr = 0, id_pc = 0x80000042; next id_pc = 0x80000046.
- Wrap and reset mid-run: pc_f = 0xFFFFFFFC → next PC is 0x80000000 (bit 31 kept); asserting reset mid-run → id_valid = 0 the next cycle and startup sequence repeats.
